// File: rtl/data_memory_bytelane.sv
// Byte-lane data memory: word/half/byte loads and stores, little-endian, with
// alignment/range faults, registered read port and an optional post-reset clear sweep.
module data_memory_bytelane #(
  parameter int          DEPTH_WORDS    = 2048,
  parameter logic [31:0] BASE_ADDR      = 32'h7FFFE000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  accessSize,
  input  logic        signExt,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        readValid,
  output logic        busy,
  output logic [1:0]  fault
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  logic [31:0]      mem_r [DEPTH_WORDS];
  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [31:0]      read_data_r;
  logic             read_valid_r;
  logic             busy_r;
  logic [1:0]       fault_r;

  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;
  logic             misaligned_s;
  logic             legal_s;
  logic             req_s;
  logic [3:0]       wr_lane_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [31:0]      wr_data_s;

  // Pick the addressed lanes out of a stored word and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic sext);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[{lane, 3'b000} +: 8];
    case (size)
      2'd0:    extract = word;
      2'd1:    extract = sext ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
      2'd2:    extract = sext ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
      default: extract = 32'h0000_0000;
    endcase
  endfunction

  // Address decode: unsigned offset compare so addresses below base never alias.
  always_comb begin
    offset_s   = address - BASE_ADDR;
    in_range_s = ({1'b0, offset_s} < SPAN);
    idx_s      = offset_s[IDX_W+1:2];
    case (accessSize)
      2'd0:    misaligned_s = (address[1:0] != 2'b00);
      2'd1:    misaligned_s = address[0];
      2'd2:    misaligned_s = 1'b0;
      default: misaligned_s = 1'b1;
    endcase
    legal_s = in_range_s && !misaligned_s;
    req_s   = (state_r == ST_IDLE) && (memRead || memWrite);
  end

  // Write-port steering: clear sweep or lane-masked store.
  always_comb begin
    wr_lane_s = 4'b0000;
    wr_idx_s  = idx_s;
    wr_data_s = writeData;
    if (state_r == ST_CLEAR) begin
      wr_lane_s = 4'b1111;
      wr_idx_s  = ptr_r;
      wr_data_s = 32'h0000_0000;
    end else if (memWrite && legal_s) begin
      case (accessSize)
        2'd0: wr_lane_s = 4'b1111;
        2'd1: begin
          wr_lane_s = address[1] ? 4'b1100 : 4'b0011;
          wr_data_s = {2{writeData[15:0]}};
        end
        2'd2: begin
          wr_lane_s = 4'b0001 << address[1:0];
          wr_data_s = {4{writeData[7:0]}};
        end
        default: wr_lane_s = 4'b0000;
      endcase
    end else begin
      wr_lane_s = 4'b0000;
    end
  end

  // Memory array; a write is dropped if reset is already asserted at the edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lane_s[i]) mem_r[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
      end
    end
  end

  // Control FSM with registered read port, strobes and faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr_r        <= '0;
      read_data_r  <= 32'h0000_0000;
      read_valid_r <= 1'b0;
      busy_r       <= CLEAR_ON_RESET;
      fault_r      <= 2'b00;
    end else begin
      read_valid_r <= 1'b0;
      fault_r      <= 2'b00;
      case (state_r)
        ST_CLEAR: begin
          ptr_r <= ptr_r + IDX_W'(1);
          if (ptr_r == IDX_W'(DEPTH_WORDS - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (req_s) begin
            fault_r <= {!in_range_s, misaligned_s};
            if (memRead) begin
              read_valid_r <= 1'b1;
              read_data_r  <= legal_s ? extract(mem_r[idx_s], accessSize, address[1:0], signExt)
                                      : 32'h0000_0000;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign readData  = read_data_r;
  assign readValid = read_valid_r;
  assign busy      = busy_r;
  assign fault     = fault_r;

endmodule
